// File: rtl/data_mem_arbiter.sv
// Two-port valid/ready arbiter sequencing accesses onto one data memory port.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              wr_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              grant;
  logic              accept;

  assign any_req = req0_valid | req1_valid;
  assign accept  = (state_q == IDLE) & any_req;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Tie goes to the port not granted last; a lone requester always wins
  always_comb begin
    grant = ~req0_valid;
    if (req0_valid & req1_valid)
      grant = ~last_q;
  end

  // Remember which port was granted on each accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= 1'b1;
    else if (accept)
      last_q <= grant;
  end
`else
  // Port 0 always wins; port 1 only when port 0 is absent
  always_comb grant = ~req0_valid;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: fixed one cycle each in ACCESS and RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch winner's request at accept, capture memory data at end of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        port_q  <= grant;
        wr_q    <= grant ? req1_write : req0_write;
        addr_q  <= grant ? req1_addr : req0_addr;
        wdata_q <= grant ? req1_wdata : req0_wdata;
      end
      if (state_q == ACCESS)
        rdata_q <= wr_q ? '0 : mem_load_data;
    end
  end

  // Outputs decoded from state; ready is held low while reset is applied
  always_comb begin
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    rsp0_valid     = 1'b0;
    rsp1_valid     = 1'b0;
    rsp0_rdata     = '0;
    rsp1_rdata     = '0;
    mem_address    = '0;
    mem_store_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    busy           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = any_req & ~rst & ~grant;
        req1_ready = any_req & ~rst & grant;
      end
      ACCESS: begin
        busy           = 1'b1;
        mem_address    = addr_q;
        mem_store_data = wdata_q;
        mem_write      = wr_q;
        mem_read       = ~wr_q;
      end
      RESP: begin
        busy       = 1'b1;
        rsp0_valid = ~port_q;
        rsp1_valid = port_q;
        rsp0_rdata = port_q ? '0 : rdata_q;
        rsp1_rdata = port_q ? rdata_q : '0;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed cases plus
// randomized two-port traffic against a transaction-level model.
module tb_data_mem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] mem_address, mem_store_data, mem_load_data;
  logic        mem_write, mem_read, busy;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_load_data(mem_load_data), .busy(busy)
  );

  // Environment memory (256 words, addresses kept below 256)
  logic [31:0] bmem [256];
  assign mem_load_data = bmem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) bmem[mem_address[7:0]] <= mem_store_data;

  // Model state: cycles since accept (0 = idle), latched transaction
  int          m_phase;
  bit          m_port, m_wr, m_last;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] rmem [256];

  // Requester state
  bit          p_valid [2];
  bit          p_write [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  bit          hold_both;
  int          last_acc;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req0_valid = p_valid[0]; req0_write = p_write[0];
    req0_addr  = p_addr[0];  req0_wdata = p_wdata[0];
    req1_valid = p_valid[1]; req1_write = p_write[1];
    req1_addr  = p_addr[1];  req1_wdata = p_wdata[1];
  endtask

  function automatic bit winner();
    if (p_valid[0] && p_valid[1]) return RR ? !m_last : 1'b0;
    return p_valid[1];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_port = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  // Drive inputs, compare every output, then advance the model over the edge
  task automatic eval();
    bit          w;
    bit          e_rdy [2];
    bit          e_rsp [2];
    logic [31:0] e_rd  [2];
    logic [31:0] e_ad, e_sd;
    bit          e_mw, e_mr, e_busy;
    drive();
    #1;
    e_rdy = '{0, 0}; e_rsp = '{0, 0}; e_rd = '{0, 0};
    e_ad = '0; e_sd = '0; e_mw = 0; e_mr = 0; e_busy = 0;
    w = winner();
    if (m_phase == 0) begin
      if (p_valid[0] || p_valid[1]) e_rdy[w] = 1;
    end else if (m_phase == 1) begin
      e_busy = 1; e_ad = m_addr; e_sd = m_wdata;
      e_mw = m_wr; e_mr = !m_wr;
    end else begin
      e_busy = 1; e_rsp[m_port] = 1;
      e_rd[m_port] = m_wr ? 32'h0 : rmem[m_addr[7:0]];
    end
    chk("ready0", req0_ready, e_rdy[0]);
    chk("ready1", req1_ready, e_rdy[1]);
    chk("rsp0_valid", rsp0_valid, e_rsp[0]);
    chk("rsp1_valid", rsp1_valid, e_rsp[1]);
    chk("rsp0_rdata", rsp0_rdata, e_rd[0]);
    chk("rsp1_rdata", rsp1_rdata, e_rd[1]);
    chk("mem_address", mem_address, e_ad);
    chk("mem_store_data", mem_store_data, e_sd);
    chk("mem_write", mem_write, e_mw);
    chk("mem_read", mem_read, e_mr);
    chk("busy", busy, e_busy);
    last_acc = -1;
    if (m_phase == 0) begin
      if (p_valid[0] || p_valid[1]) begin
        m_port = w; m_wr = p_write[w];
        m_addr = p_addr[w]; m_wdata = p_wdata[w];
        m_last = w; last_acc = int'(w);
        if (!hold_both) p_valid[w] = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_wr) rmem[m_addr[7:0]] = m_wdata;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive();
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    eval();
  endtask

  task automatic req(int p, bit wr, logic [31:0] a, logic [31:0] d);
    p_valid[p] = 1; p_write[p] = wr; p_addr[p] = a; p_wdata[p] = d;
  endtask

  initial begin
    rst = 1'b0;
    hold_both = 0;
    for (int i = 0; i < 2; i++) req(i, 0, 0, 0);
    p_valid = '{0, 0};
    for (int i = 0; i < 256; i++) begin
      bmem[i] = $urandom;
      rmem[i] = bmem[i];
    end
    model_reset();
    drive();
    do_reset();

    // Continuous tie: grant sequence and first-tie winner after reset
    hold_both = 1;
    req(0, 0, 32'h20, 0);
    req(1, 0, 32'h30, 0);
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k % 3 == 0)
        chk("tie_grant", last_acc, RR ? (k / 3) % 2 : 0);
      if (!RR) chk("fixed_ready1", req1_ready, 0);
    end
    hold_both = 0;
    p_valid = '{0, 0};
    cycle();

    // Port 0 store alone; its address input changes right after accept
    req(0, 1, 32'h10, 32'hDEADBEEF);
    cycle();
    chk("t1_ready0", req0_ready, 1);
    p_addr[0] = 32'h99;
    cycle();
    chk("t1_mem_write", mem_write, 1);
    chk("t1_mem_address", mem_address, 32'h10);
    chk("t1_store_data", mem_store_data, 32'hDEADBEEF);
    cycle();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_rdata", rsp0_rdata, 0);
    chk("t1_rsp1_valid", rsp1_valid, 0);

    // Port 1 load of the stored word
    req(1, 0, 32'h10, 32'h0);
    cycle();
    chk("t2_ready1", req1_ready, 1);
    cycle();
    chk("t2_mem_read", mem_read, 1);
    cycle();
    chk("t2_rsp1_valid", rsp1_valid, 1);
    chk("t2_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);

    // Pending port 0 address changes while ready is low
    req(1, 0, 32'h20, 32'h0);
    cycle();
    req(0, 0, 32'h77, 32'h0);
    cycle();
    chk("t5_wait_ready0", req0_ready, 0);
    p_addr[0] = 32'h55;
    cycle();
    p_addr[0] = 32'h10;
    cycle();
    chk("t5_accept0", req0_ready, 1);
    cycle();
    chk("t5_mem_address", mem_address, 32'h10);
    cycle();
    chk("t5_rdata", rsp0_rdata, 32'hDEADBEEF);

    // Store dropped by reset during ACCESS
    req(0, 1, 32'h40, 32'h11111111);
    repeat (3) cycle();
    req(0, 1, 32'h40, 32'h22222222);
    cycle();
    chk("t4_accept", req0_ready, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_no_rsp0", rsp0_valid, 0);
    end
    req(1, 0, 32'h40, 32'h0);
    repeat (3) cycle();
    chk("t4_prior", rsp1_rdata, 32'h11111111);

    // Randomized traffic with mutating pending requests and rare resets
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_valid[p]) begin
          if ($urandom % 3 == 0)
            req(p, 1'($urandom % 2), 32'($urandom % 256), $urandom);
        end else if ($urandom % 4 == 0) begin
          p_addr[p] = 32'($urandom % 256);
          p_wdata[p] = $urandom;
          p_write[p] = 1'($urandom % 2);
        end
      end
      if ($urandom % 400 == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
